// File: rtl/obi_rr_arbiter.sv
// Round-robin N:1 OBI arbiter: shares one subordinate port among NumMgr managers and
// routes in-order responses back to their issuer through an ID FIFO.
module obi_rr_arbiter #(
    parameter int unsigned NumMgr    = 2,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned MaxTrans  = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumMgr-1:0]             mgr_req_i,
    output logic [NumMgr-1:0]             mgr_gnt_o,
    input  logic [NumMgr*AddrWidth-1:0]   mgr_addr_i,
    input  logic [NumMgr-1:0]             mgr_we_i,
    input  logic [NumMgr*DataWidth/8-1:0] mgr_be_i,
    input  logic [NumMgr*DataWidth-1:0]   mgr_wdata_i,
    output logic [NumMgr-1:0]             mgr_rvalid_o,
    output logic [DataWidth-1:0]          mgr_rdata_o,
    output logic                          mgr_err_o,
    output logic                          sbr_req_o,
    input  logic                          sbr_gnt_i,
    output logic [AddrWidth-1:0]          sbr_addr_o,
    output logic                          sbr_we_o,
    output logic [DataWidth/8-1:0]        sbr_be_o,
    output logic [DataWidth-1:0]          sbr_wdata_o,
    input  logic                          sbr_rvalid_i,
    input  logic [DataWidth-1:0]          sbr_rdata_i,
    input  logic                          sbr_err_i,
    output logic                          busy_o,
    output logic                          spurious_rsp_o
);
    localparam int unsigned BeWidth = DataWidth / 8;
    localparam int unsigned IdxW    = (NumMgr > 1) ? $clog2(NumMgr) : 1;
    localparam int unsigned PtrW    = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
    localparam int unsigned CntW    = $clog2(MaxTrans + 1);

    logic [AddrWidth-1:0] addr_arr  [NumMgr];
    logic [BeWidth-1:0]   be_arr    [NumMgr];
    logic [DataWidth-1:0] wdata_arr [NumMgr];

    for (genvar gi = 0; gi < NumMgr; gi++) begin : g_unpack
        assign addr_arr[gi]  = mgr_addr_i[gi*AddrWidth +: AddrWidth];
        assign be_arr[gi]    = mgr_be_i[gi*BeWidth +: BeWidth];
        assign wdata_arr[gi] = mgr_wdata_i[gi*DataWidth +: DataWidth];
    end

    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
    logic            lock_q, lock_d;
    logic [IdxW-1:0] locked_idx_q, locked_idx_d;
    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic            spurious_q, spurious_d;
    logic [IdxW-1:0] fifo_q [MaxTrans];

    logic [IdxW-1:0] rr_winner, winner, sel;
    logic            rr_found;
    int unsigned     cand;
    logic            handshake, pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxTrans - 1)) ? '0 : p + 1'b1;
    endfunction

    // First requester at or after rr_ptr, wrapping around.
    always_comb begin
        rr_winner = '0;
        rr_found  = 1'b0;
        cand      = 0;
        for (int unsigned k = 0; k < NumMgr; k++) begin
            cand = 32'(rr_ptr_q) + k;
            if (cand >= NumMgr) begin
                cand = cand - NumMgr;
            end
            if (!rr_found && mgr_req_i[cand[IdxW-1:0]]) begin
                rr_winner = cand[IdxW-1:0];
                rr_found  = 1'b1;
            end
        end
    end

    assign winner    = lock_q ? locked_idx_q : rr_winner;
    // Full is judged on the registered count so rvalid never feeds the request path.
    assign sbr_req_o = rst_ni & ((|mgr_req_i) | lock_q) & (count_q < CntW'(MaxTrans));
    assign sel       = sbr_req_o ? winner : '0;
    assign handshake = sbr_req_o & sbr_gnt_i;
    assign pop       = sbr_rvalid_i & (count_q != '0) & rst_ni;

    assign sbr_addr_o  = addr_arr[sel];
    assign sbr_we_o    = mgr_we_i[sel];
    assign sbr_be_o    = be_arr[sel];
    assign sbr_wdata_o = wdata_arr[sel];

    assign mgr_rdata_o    = sbr_rdata_i;
    assign mgr_err_o      = sbr_err_i;
    assign busy_o         = (count_q != '0);
    assign spurious_rsp_o = spurious_q;

    always_comb begin
        mgr_gnt_o    = '0;
        mgr_rvalid_o = '0;
        if (handshake) begin
            mgr_gnt_o[winner] = 1'b1;
        end
        if (pop) begin
            mgr_rvalid_o[fifo_q[rd_ptr_q]] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        lock_d       = lock_q;
        locked_idx_d = locked_idx_q;
        count_d      = count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        spurious_d   = spurious_q;
        if (handshake) begin
            rr_ptr_d = (winner == IdxW'(NumMgr - 1)) ? '0 : winner + 1'b1;
            lock_d   = 1'b0;
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else if (sbr_req_o) begin
            // Hold the stalled selection so the downstream request stays stable.
            lock_d       = 1'b1;
            locked_idx_d = winner;
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({handshake, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (sbr_rvalid_i && (count_q == '0)) begin
            spurious_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q     <= '0;
            lock_q       <= 1'b0;
            locked_idx_q <= '0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            spurious_q   <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            lock_q       <= lock_d;
            locked_idx_q <= locked_idx_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            spurious_q   <= spurious_d;
        end
    end

    // Entries are only read while count>0, so the storage needs no reset.
    always_ff @(posedge clk_i) begin
        if (handshake) begin
            fifo_q[wr_ptr_q] <= winner;
        end
    end

endmodule
